// File: rtl/apb_slave_regfile_if.sv
// Purpose: APB bus bundle between one requester and one regfile completer slot.
// Latency: none, wires only.
// Backpressure: completer stretches transfers through Pready; requester holds its request until then.
//
// Signals:
//   Pselx[2:0]  one-hot slave select        Penable  access phase
//   Pwrite      1=write, 0=read             Paddr    byte address
//   Pwdata      write data                  Prdata   read data, valid with Pready on reads
//   Pready      transfer completes when high
//   Pslverr     error response, qualified by Pready
interface apb_slave_regfile_if;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// Purpose: APB completer holding NUM_REGS 32-bit read/write registers for one Pselx slot.
// Latency: WAIT_STATES+1 access cycles after the setup phase; every output is registered.
// Backpressure: Pready held low for WAIT_STATES access cycles; a dropped select/enable aborts the transfer.
//
// Ports:
//   Hclk     rising-edge clock for all state
//   Hresetn  asynchronous active-low reset; clears FSM, outputs and all registers
//   apb      slave modport of apb_slave_regfile_if (Pselx/Penable/Pwrite/Paddr/Pwdata in,
//            Prdata/Pready/Pslverr out)
//
// Optional feature: define APB_SLVERR_EN to raise Pslverr together with Pready on
// out-of-range accesses. Without it Pslverr is tied to 0 and no error logic exists.
module apb_slave_regfile #(
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0,
    parameter int SLV_IDX     = 0,
    parameter int ADDR_LSB    = 2
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    apb_slave_regfile_if.slave    apb
);

    // A single-register file still gets a 1-bit index; the range check below
    // turns index 1 into a miss, so the extra bit behaves like an upper address bit.
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               hit_q, hit_d;
    logic               wr_q, wr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        prdata_q, prdata_d;
    logic               pready_q, pready_d;

    logic [31:0]        regs_q [NUM_REGS];

    logic               sel;
    logic [IDX_W-1:0]   live_idx;
    logic               live_hit;
    logic               enter_resp;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_hit;
    logic               rd_wr;
    logic               do_write;

    // Address offset bits and the other slaves' select lines are deliberately ignored.
    logic               unused_bus;
    assign unused_bus = ^{apb.Paddr, apb.Pselx};

    assign sel      = apb.Pselx[SLV_IDX];
    assign live_idx = apb.Paddr[ADDR_LSB +: IDX_W];
    // Hit needs every address bit above the index to be zero, otherwise an
    // aliased address would land on a real register.
    assign live_hit = ((apb.Paddr >> (ADDR_LSB + IDX_W)) == 32'd0)
                   && (32'(live_idx) < NUM_REGS);

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        hit_d      = hit_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        pready_d   = 1'b0;
        prdata_d   = '0;
        enter_resp = 1'b0;
        do_write   = 1'b0;
        // The response normally reads from the captured request; with zero wait
        // states the capture and the response happen on the same edge, so the
        // live bus values are used instead.
        rd_idx     = idx_q;
        rd_hit     = hit_q;
        rd_wr      = wr_q;

        case (state_q)
            ST_IDLE: begin
                if (sel && !apb.Penable) begin
                    idx_d   = live_idx;
                    hit_d   = live_hit;
                    wr_d    = apb.Pwrite;
                    wdata_d = apb.Pwdata;
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                        rd_idx     = live_idx;
                        rd_hit     = live_hit;
                        rd_wr      = apb.Pwrite;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (!sel || !apb.Penable) begin
                    // Requester broke the protocol: drop the transfer, nothing is written.
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end

            ST_RESP: begin
                // Write commits on the edge that closes the Pready cycle, so a
                // following setup phase already sees the new value.
                do_write = sel && apb.Penable && wr_q && hit_q;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            pready_d = 1'b1;
            prdata_d = (!rd_wr && rd_hit) ? regs_q[rd_idx] : '0;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            hit_q    <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            prdata_q <= '0;
            pready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            hit_q    <= hit_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            prdata_q <= prdata_d;
            pready_q <= pready_d;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (do_write) begin
            regs_q[idx_q] <= wdata_q;
        end
    end

    assign apb.Prdata = prdata_q;
    assign apb.Pready = pready_q;

`ifdef APB_SLVERR_EN
    // Error flag follows Pready: raised on entry to the response cycle for a
    // miss, cleared again when the response cycle ends.
    logic pslverr_q;
    logic pslverr_d;

    always_comb begin
        pslverr_d = 1'b0;
        if (enter_resp) begin
            pslverr_d = !rd_hit;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= pslverr_d;
        end
    end

    assign apb.Pslverr = pslverr_q;
`else
    assign apb.Pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Purpose: bench for apb_slave_regfile with two slots sharing one APB bus.
// Latency: slot A has no wait states, slot B has three.
// Backpressure: the bench driver waits on Pready of the selected slot, bounded per transfer.
module tb_apb_slave_regfile;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    int total = 0;
    int bad   = 0;

    // Slot 0 = "A" (Pselx bit 1, no waits), slot 1 = "B" (Pselx bit 0, 3 waits).
    localparam int WS   [2] = '{0, 3};
    localparam int SIDX [2] = '{1, 0};

    apb_slave_regfile_if if_a ();
    apb_slave_regfile_if if_b ();

    assign if_a.Pselx   = pselx;
    assign if_a.Penable = penable;
    assign if_a.Pwrite  = pwrite;
    assign if_a.Paddr   = paddr;
    assign if_a.Pwdata  = pwdata;
    assign if_b.Pselx   = pselx;
    assign if_b.Penable = penable;
    assign if_b.Pwrite  = pwrite;
    assign if_b.Paddr   = paddr;
    assign if_b.Pwdata  = pwdata;

    apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(0), .SLV_IDX(1), .ADDR_LSB(2)) u_dut_a (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .apb     (if_a)
    );

    apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(3), .SLV_IDX(0), .ADDR_LSB(2)) u_dut_b (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .apb     (if_b)
    );

    always #5 Hclk = ~Hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, need 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: register contents per slot plus "access cycle number
    // since setup". A transfer completes on access cycle WS+1; reads return
    // the stored word, misses read 0 and never write.
    // ------------------------------------------------------------------
    logic [31:0] mregs [2][8];
    bit          m_act [2];
    int          m_acc [2];
    bit          m_wr  [2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wd  [2];
    logic        e_rdy, e_err, m_sel, m_hit;
    logic [31:0] e_dat;
    logic        a_rdy, a_err;
    logic [31:0] a_dat;

    initial begin
        for (int s = 0; s < 2; s++) begin
            m_act[s] = 1'b0;
            m_acc[s] = 0;
            for (int r = 0; r < 8; r++) mregs[s][r] = '0;
        end
        forever begin
            @(negedge Hclk);
            for (int s = 0; s < 2; s++) begin
                m_sel = pselx[SIDX[s]];
                e_rdy = 1'b0;
                e_dat = '0;
                e_err = 1'b0;
                if (!Hresetn) begin
                    m_act[s] = 1'b0;
                    for (int r = 0; r < 8; r++) mregs[s][r] = '0;
                end else if (m_sel && !penable) begin
                    m_act[s]  = 1'b1;
                    m_acc[s]  = 0;
                    m_wr[s]   = pwrite;
                    m_addr[s] = paddr;
                    m_wd[s]   = pwdata;
                end else if (m_act[s] && m_sel && penable) begin
                    m_acc[s]++;
                    if (m_acc[s] == WS[s] + 1) begin
                        m_hit = (m_addr[s] >> 2) < 8;
                        e_rdy = 1'b1;
                        e_dat = (!m_wr[s] && m_hit) ? mregs[s][m_addr[s][4:2]] : 32'h0;
`ifdef APB_SLVERR_EN
                        e_err = !m_hit;
`endif
                        m_act[s] = 1'b0;
                        if (m_wr[s] && m_hit) mregs[s][m_addr[s][4:2]] = m_wd[s];
                    end
                end else begin
                    m_act[s] = 1'b0;
                end
                a_rdy = (s == 0) ? if_a.Pready  : if_b.Pready;
                a_dat = (s == 0) ? if_a.Prdata  : if_b.Prdata;
                a_err = (s == 0) ? if_a.Pslverr : if_b.Pslverr;
                chk($sformatf("slot%0d_Pready", s),  {31'b0, a_rdy}, {31'b0, e_rdy});
                chk($sformatf("slot%0d_Prdata", s),  a_dat, e_dat);
                chk($sformatf("slot%0d_Pslverr", s), {31'b0, a_err}, {31'b0, e_err});
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver. Entered and left at #1 after a rising edge; a following call
    // issues its setup phase immediately, giving back-to-back transfers.
    // ------------------------------------------------------------------
    task automatic xfer(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int waits, output logic err);
        logic rdy;
        pselx   = 3'b001 << SIDX[s];
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        @(posedge Hclk); #1;
        penable = 1'b1;
        waits   = 0;
        rd      = '0;
        err     = 1'b0;
        while (1) begin
            @(negedge Hclk);
            rdy = (s == 0) ? if_a.Pready : if_b.Pready;
            if (rdy) begin
                rd  = (s == 0) ? if_a.Prdata  : if_b.Prdata;
                err = (s == 0) ? if_a.Pslverr : if_b.Pslverr;
                break;
            end
            waits++;
            if (waits > 20) begin
                total++;
                bad++;
                $display("FAIL timeout slot%0d addr 0x%08h: Pready low for %0d cycles, need high within %0d",
                         s, addr, waits, WS[s] + 1);
                break;
            end
            @(posedge Hclk); #1;
        end
        @(posedge Hclk); #1;
    endtask

    task automatic idle();
        pselx   = 3'b000;
        penable = 1'b0;
        @(posedge Hclk); #1;
    endtask

    logic [31:0] rd;
    int          w;
    logic        e;
    logic        exp_oor_err;

    initial begin
`ifdef APB_SLVERR_EN
        exp_oor_err = 1'b1;
`else
        exp_oor_err = 1'b0;
`endif
        Hresetn = 1'b0;
        pselx   = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        repeat (2) @(posedge Hclk);
        @(negedge Hclk);
        chk("reset_A_Pready", {31'b0, if_a.Pready}, 32'h0);
        chk("reset_B_Prdata", if_b.Prdata, 32'h0);
        @(posedge Hclk); #1;
        Hresetn = 1'b1;
        idle();

        // Zero-wait slot: write then read back, completion in the first access cycle.
        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, rd, w, e);
        chk("A_wr08_waits", w, 0);
        xfer(0, 1'b0, 32'h08, 32'h0, rd, w, e);
        chk("A_rd08_data", rd, 32'hDEADBEEF);
        chk("A_rd08_waits", w, 0);
        idle();

        // Three-wait slot: exactly three access cycles with Pready low.
        xfer(1, 1'b1, 32'h04, 32'h12345678, rd, w, e);
        chk("B_wr04_waits", w, 3);
        idle();
        xfer(1, 1'b0, 32'h04, 32'h0, rd, w, e);
        chk("B_rd04_waits", w, 3);
        chk("B_rd04_data", rd, 32'h12345678);
        idle();

        // Back-to-back write/read, then a write to the other slot must not touch A.
        xfer(0, 1'b1, 32'h00, 32'h1, rd, w, e);
        xfer(0, 1'b0, 32'h00, 32'h0, rd, w, e);
        chk("A_b2b_rd00", rd, 32'h1);
        xfer(1, 1'b1, 32'h00, 32'h77, rd, w, e);
        xfer(0, 1'b0, 32'h00, 32'h0, rd, w, e);
        chk("A_rd00_after_B_wr", rd, 32'h1);
        idle();

        // Select line belonging to neither slot: no response anywhere.
        pselx = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFFFF_FFFF;
        @(posedge Hclk); #1;
        penable = 1'b1;
        repeat (3) @(posedge Hclk);
        #1;
        idle();

        // Out-of-range: 0x40 aliases index 0 if upper bits were ignored.
        xfer(0, 1'b1, 32'h40, 32'h55, rd, w, e);
        chk("A_wr40_err", {31'b0, e}, {31'b0, exp_oor_err});
        xfer(0, 1'b0, 32'h40, 32'h0, rd, w, e);
        chk("A_rd40_data", rd, 32'h0);
        chk("A_rd40_err", {31'b0, e}, {31'b0, exp_oor_err});
        xfer(0, 1'b0, 32'h00, 32'h0, rd, w, e);
        chk("A_rd00_after_oor", rd, 32'h1);
        chk("A_rd00_err", {31'b0, e}, 32'h0);
        xfer(0, 1'b0, 32'h0B, 32'h0, rd, w, e);
        chk("A_rd0B_offset_ignored", rd, 32'hDEADBEEF);
        idle();

        // Abort: drop select in the middle of B's wait states on a write.
        pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hA5;
        @(posedge Hclk); #1;
        penable = 1'b1;
        @(posedge Hclk); #1;
        @(posedge Hclk); #1;
        pselx = 3'b000; penable = 1'b0;
        repeat (3) @(posedge Hclk);
        #1;
        xfer(1, 1'b0, 32'h0C, 32'h0, rd, w, e);
        chk("B_rd0C_after_abort", rd, 32'h0);
        idle();

        // Reset in the middle of B's wait states.
        pselx = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 32'h04;
        @(posedge Hclk); #1;
        penable = 1'b1;
        @(posedge Hclk); #1;
        Hresetn = 1'b0;
        pselx   = 3'b000;
        penable = 1'b0;
        @(negedge Hclk);
        chk("midreset_B_Pready", {31'b0, if_b.Pready}, 32'h0);
        chk("midreset_B_Prdata", if_b.Prdata, 32'h0);
        @(posedge Hclk); #1;
        Hresetn = 1'b1;
        idle();
        for (int r = 0; r < 8; r++) begin
            xfer(0, 1'b0, 32'(r * 4), 32'h0, rd, w, e);
            chk($sformatf("A_after_reset_reg%0d", r), rd, 32'h0);
            xfer(1, 1'b0, 32'(r * 4), 32'h0, rd, w, e);
            chk($sformatf("B_after_reset_reg%0d", r), rd, 32'h0);
        end
        idle();
        repeat (2) @(posedge Hclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
